// File: rtl/num_sep_matrix_loader.sv
// Purpose : sequences the ASCII number separator (clear, wait, read back), validates the
//           leading rows/cols header and streams the remaining numbers as matrix elements.
// Latency : sep_done -> first elem_valid in 6th cycle; >= 2 cycles per element.
// Backpr. : elem_data/elem_valid/elem_last held stable until elem_ready; RAM reads stall meanwhile.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, abort, busy          control: start accepted in IDLE only, abort returns to IDLE
//   sep_buf_clear               clear pulse (CLEAR_CYCLES long) to the separator
//   sep_done, sep_invalid       separator status levels
//   sep_num_count               number of integers the separator produced
//   sep_rd_addr, sep_rd_data    separator RAM read port (data one cycle after address)
//   mat_rows, mat_cols          validated header, valid from header check until next start
//   elem_data/valid/ready/last  element stream
//   load_done, load_err         one-cycle completion pulses
//   err_code                    0 invalid, 1 timeout, 2 bad dims, 3 count mismatch
module num_sep_matrix_loader #(
    parameter int MAX_DIM      = 5,
    parameter int DIM_WIDTH    = 3,
    parameter int ADDR_WIDTH   = 11,
    parameter int DATA_WIDTH   = 32,
    parameter int CLEAR_CYCLES = 4,
    parameter int TIMEOUT      = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  sep_buf_clear,
    input  logic                  sep_done,
    input  logic                  sep_invalid,
    input  logic [10:0]           sep_num_count,
    output logic [ADDR_WIDTH-1:0] sep_rd_addr,
    input  logic [DATA_WIDTH-1:0] sep_rd_data,
    output logic [DIM_WIDTH-1:0]  mat_rows,
    output logic [DIM_WIDTH-1:0]  mat_cols,
    output logic [DATA_WIDTH-1:0] elem_data,
    output logic                  elem_valid,
    input  logic                  elem_ready,
    output logic                  elem_last,
    output logic                  load_done,
    output logic                  load_err,
    output logic [1:0]            err_code
);

    // Element counts are evaluated at the width of sep_num_count.
    localparam int CW      = 11;
    localparam int CNT_MAX = (TIMEOUT > CLEAR_CYCLES) ? TIMEOUT : CLEAR_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic signed [DATA_WIDTH-1:0] ZERO_S = '0;
    localparam logic signed [DATA_WIDTH-1:0] MAX_S  = DATA_WIDTH'(MAX_DIM);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WAIT,
        ST_HDR0,
        ST_HDR1,
        ST_HDR2,
        ST_CHECK,
        ST_ADDR,
        ST_DATA,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [DATA_WIDTH-1:0]   rows_raw_q, cols_raw_q;
    logic [DIM_WIDTH-1:0]    mat_rows_q, mat_cols_q;
    logic [CW-1:0]           idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [1:0]              err_q, err_d;
    logic [DATA_WIDTH-1:0]   elem_q;
    logic                    held_q;

    logic signed [DATA_WIDTH-1:0] rows_s, cols_s;
    logic [CW-1:0]           rows_ext, cols_ext, elem_total;
    logic                    dims_bad, count_ok, is_last;

    // Header checks use the full signed word so negative or huge values are rejected
    // before the low bits are trusted for the element count.
    assign rows_s     = rows_raw_q;
    assign cols_s     = cols_raw_q;
    assign dims_bad   = (rows_s <= ZERO_S) || (rows_s > MAX_S) ||
                        (cols_s <= ZERO_S) || (cols_s > MAX_S);
    assign rows_ext   = CW'(rows_raw_q[DIM_WIDTH-1:0]);
    assign cols_ext   = CW'(cols_raw_q[DIM_WIDTH-1:0]);
    assign elem_total = rows_ext * cols_ext;
    assign count_ok   = (sep_num_count == (CW'(2) + elem_total));
    assign is_last    = (idx_q == (elem_total - CW'(1)));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                    err_d   = 2'd0;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == CNT_W'(CLEAR_CYCLES - 1)) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (sep_invalid) begin
                    state_d = ST_ERR;
                    err_d   = 2'd0;
                end else if (sep_done) begin
                    state_d = ST_HDR0;
                    addr_d  = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                    err_d   = 2'd1;
                end
            end
            ST_HDR0: begin
                state_d = ST_HDR1;
                addr_d  = ADDR_WIDTH'(1);
            end
            ST_HDR1: state_d = ST_HDR2;
            ST_HDR2: state_d = ST_CHECK;
            ST_CHECK: begin
                if (dims_bad) begin
                    state_d = ST_ERR;
                    err_d   = 2'd2;
                end else if (!count_ok) begin
                    state_d = ST_ERR;
                    err_d   = 2'd3;
                end else begin
                    state_d = ST_ADDR;
                    idx_d   = '0;
                    addr_d  = ADDR_WIDTH'(2);
                end
            end
            ST_ADDR: state_d = ST_DATA;
            ST_DATA: begin
                if (elem_ready) begin
                    if (is_last) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ADDR;
                        idx_d   = idx_q + CW'(1);
                        // address of the next element: 2 + (idx + 1)
                        addr_d  = ADDR_WIDTH'(idx_q) + ADDR_WIDTH'(3);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // abort wins over everything, including a start in IDLE
        if (abort) begin
            state_d = ST_IDLE;
            idx_d   = idx_q;
            addr_d  = addr_q;
            err_d   = err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rows_raw_q <= '0;
            cols_raw_q <= '0;
            mat_rows_q <= '0;
            mat_cols_q <= '0;
            idx_q      <= '0;
            addr_q     <= '0;
            err_q      <= '0;
            elem_q     <= '0;
            held_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            err_q   <= err_d;

            // one counter serves both CLEAR length and WAIT timeout; restarts on every state change
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (state_q == ST_CLEAR || state_q == ST_WAIT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (state_q == ST_HDR1) rows_raw_q <= sep_rd_data;
            if (state_q == ST_HDR2) cols_raw_q <= sep_rd_data;

            if (state_q == ST_IDLE && start && !abort) begin
                mat_rows_q <= '0;
                mat_cols_q <= '0;
            end else if (state_q == ST_CHECK && state_d == ST_ADDR) begin
                mat_rows_q <= rows_raw_q[DIM_WIDTH-1:0];
                mat_cols_q <= cols_raw_q[DIM_WIDTH-1:0];
            end

            // RAM data is only valid in the first S_DATA cycle's own timing slot, so it is
            // passed straight through then and captured for any stall cycles that follow.
            if (state_q == ST_DATA) begin
                if (!held_q) elem_q <= sep_rd_data;
                held_q <= (state_d == ST_DATA);
            end else begin
                held_q <= 1'b0;
            end
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign sep_buf_clear = (state_q == ST_CLEAR);
    assign sep_rd_addr   = addr_q;
    assign mat_rows      = mat_rows_q;
    assign mat_cols      = mat_cols_q;
    assign elem_valid    = (state_q == ST_DATA);
    assign elem_last     = elem_valid && is_last;
    assign elem_data     = (elem_valid && !held_q) ? sep_rd_data : elem_q;
    assign load_done     = (state_q == ST_DONE);
    assign load_err      = (state_q == ST_ERR);
    assign err_code      = err_q;

endmodule

// File: tb/tb_num_sep_matrix_loader.sv
// Purpose : self-checking bench for num_sep_matrix_loader against a payload-level reference model.
// Latency : n/a (bench).
// Backpr. : elem_ready driven as always-on, 1-of-3, random or never, per scenario.
module tb_num_sep_matrix_loader;

    localparam int MAXD = 5;
    localparam int CLR  = 4;
    localparam int TO   = 50;

    logic        clk, rst_n, start, abort, busy, sep_buf_clear, sep_done, sep_invalid;
    logic [10:0] sep_num_count;
    logic [10:0] sep_rd_addr;
    logic [31:0] sep_rd_data;
    logic [2:0]  mat_rows, mat_cols;
    logic [31:0] elem_data;
    logic        elem_valid, elem_ready, elem_last, load_done, load_err;
    logic [1:0]  err_code;

    num_sep_matrix_loader #(
        .MAX_DIM(MAXD), .DIM_WIDTH(3), .ADDR_WIDTH(11), .DATA_WIDTH(32),
        .CLEAR_CYCLES(CLR), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy),
        .sep_buf_clear(sep_buf_clear), .sep_done(sep_done), .sep_invalid(sep_invalid),
        .sep_num_count(sep_num_count), .sep_rd_addr(sep_rd_addr), .sep_rd_data(sep_rd_data),
        .mat_rows(mat_rows), .mat_cols(mat_cols), .elem_data(elem_data),
        .elem_valid(elem_valid), .elem_ready(elem_ready), .elem_last(elem_last),
        .load_done(load_done), .load_err(load_err), .err_code(err_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // separator RAM: synchronous read, one cycle latency
    logic [31:0] mem [0:2047];
    always @(posedge clk) sep_rd_data <= mem[sep_rd_addr];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- monitor ----------------
    bit          mon_en = 0;
    int          cyc = 0;
    int          done_cnt, err_cnt, done_cyc;
    int          got_q[$];
    int          last_q[$];
    int          hs_cyc[$];
    bit          prev_v = 0, prev_r = 0, prev_l = 0, prev_abort = 0;
    logic [31:0] prev_d = '0;

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (load_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (load_err) err_cnt++;
            if (prev_v && !prev_r && !prev_abort && rst_n) begin
                total++;
                assert (elem_valid === 1'b1 && elem_data === prev_d && elem_last === prev_l) else begin
                    bad++;
                    $error("FAIL hold_stable: observed valid=%0b data=%0d last=%0b expected valid=1 data=%0d last=%0b",
                           elem_valid, elem_data, elem_last, prev_d, prev_l);
                end
            end
            if (elem_valid && elem_ready) begin
                got_q.push_back(int'(elem_data));
                if (elem_last) last_q.push_back(got_q.size() - 1);
                hs_cyc.push_back(cyc);
            end
        end
        prev_v     = elem_valid;
        prev_r     = elem_ready;
        prev_d     = elem_data;
        prev_l     = elem_last;
        prev_abort = abort;
    end

    // ---------------- ready driver ----------------
    int rdy_mode = 0;
    initial begin
        elem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       elem_ready = 1'b1;
                1:       elem_ready = (cyc % 3 == 0);
                2:       elem_ready = 1'($urandom % 2);
                default: elem_ready = 1'b0;
            endcase
        end
    end

    // ---------------- reference model ----------------
    // Outcome from the payload alone: code -1 means success with r*c elements at mem[2..].
    task automatic model(input int cnt, input bit inv, output int code, output int r, output int c);
        r = int'($signed(mem[0]));
        c = int'($signed(mem[1]));
        if (inv)                                          code = 0;
        else if (r < 1 || r > MAXD || c < 1 || c > MAXD)  code = 2;
        else if (cnt != 2 + r * c)                        code = 3;
        else                                              code = -1;
    endtask

    task automatic load_payload(input int r, input int c, input int base);
        mem[0] = r;
        mem[1] = c;
        for (int i = 0; i < 40; i++) mem[2 + i] = base + i + 1;
    endtask

    task automatic begin_run();
        got_q.delete();
        last_q.delete();
        hs_cyc.delete();
        done_cnt = 0;
        err_cnt  = 0;
        done_cyc = 0;
        mon_en   = 1;
    endtask

    // start, check the clear pulse; returns at the negedge of the first WAIT cycle
    task automatic start_and_clear(input string name);
        int n;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check({name, ".busy_after_start"}, busy, 1);
        n = 0;
        while (sep_buf_clear === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check({name, ".clear_len"}, n, CLR);
    endtask

    task automatic run_case(input string name, input int cnt, input bit inv,
                            input int delay, input int rmode);
        int code, r, c, nel, n, exp_n;
        bit succ;
        model(cnt, inv, code, r, c);
        succ = (code < 0);
        nel  = succ ? r * c : 0;
        rdy_mode      = rmode;
        sep_num_count = cnt[10:0];
        begin_run();
        start_and_clear(name);
        repeat (delay) @(posedge clk);
        #1;
        sep_done    = 1'b1;
        sep_invalid = inv;
        // negedges counted from the cycle in which sep_done is first sampled
        n = 0;
        while (!elem_valid && !load_err && n < 20) begin
            @(negedge clk);
            n++;
        end
        exp_n = succ ? 7 : (code == 0 ? 2 : 6);
        check({name, ".first_resp_cycle"}, n, exp_n);
        n = 0;
        while (!load_done && !load_err && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, ".end_pulse_seen"}, (n < 400), 1);
        check({name, ".busy_in_pulse"}, busy, 1);
        @(negedge clk);
        check({name, ".busy_after"}, busy, 0);
        @(posedge clk); #1;
        sep_done    = 1'b0;
        sep_invalid = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 0;
        check({name, ".done_cnt"}, done_cnt, succ ? 1 : 0);
        check({name, ".err_cnt"}, err_cnt, succ ? 0 : 1);
        check({name, ".err_code"}, err_code, succ ? 0 : code);
        check({name, ".rows"}, mat_rows, succ ? r : 0);
        check({name, ".cols"}, mat_cols, succ ? c : 0);
        check({name, ".n_elems"}, got_q.size(), nel);
        for (int i = 0; i < nel && i < got_q.size(); i++)
            check({name, ".elem"}, got_q[i], mem[2 + i]);
        check({name, ".n_last"}, last_q.size(), succ ? 1 : 0);
        if (succ && last_q.size() == 1) begin
            check({name, ".last_pos"}, last_q[0], nel - 1);
            check({name, ".done_after_last"}, done_cyc, hs_cyc[hs_cyc.size() - 1] + 1);
        end
        if (succ && rmode == 0 && hs_cyc.size() == nel && nel > 1)
            check({name, ".throughput"}, hs_cyc[nel - 1] - hs_cyc[0], 2 * (nel - 1));
    endtask

    initial begin
        int k;
        start = 0; abort = 0; sep_done = 0; sep_invalid = 0; sep_num_count = '0;
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.busy", busy, 0);
        check("reset.clear", sep_buf_clear, 0);
        check("reset.addr", sep_rd_addr, 0);
        check("reset.rows", mat_rows, 0);
        check("reset.cols", mat_cols, 0);
        check("reset.valid", elem_valid, 0);
        check("reset.last", elem_last, 0);
        check("reset.data", elem_data, 0);
        check("reset.done", load_done, 0);
        check("reset.err", load_err, 0);
        check("reset.code", err_code, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // directed payload "2 3 1 2 3 4 5 6"
        load_payload(2, 3, 0);
        run_case("basic", 8, 0, 2, 0);
        run_case("ready_1of3", 8, 0, 3, 1);
        run_case("inv_and_done", 8, 1, 1, 0);
        load_payload(6, 2, 10);
        run_case("hdr_6_2", 14, 0, 1, 0);
        load_payload(0, 3, 10);
        run_case("hdr_0_3", 2, 0, 1, 0);
        load_payload(-1, 2, 10);
        run_case("hdr_neg1_2", 0, 0, 1, 0);
        load_payload(2, 2, 20);
        run_case("count_mismatch", 5, 0, 1, 0);

        // timeout: no separator response
        begin_run();
        start_and_clear("timeout");
        k = 1;
        while (!load_err && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("timeout.err_cycle", k, TO + 1);
        check("timeout.err_code", err_code, 1);
        repeat (3) @(negedge clk);
        mon_en = 0;
        check("timeout.err_cnt", err_cnt, 1);
        check("timeout.done_cnt", done_cnt, 0);
        check("timeout.busy", busy, 0);

        // abort while an element is stalled
        load_payload(2, 3, 0);
        sep_num_count = 11'd8;
        rdy_mode = 3;
        begin_run();
        start_and_clear("abort");
        @(posedge clk); #1 sep_done = 1'b1;
        k = 0;
        while (!elem_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("abort.valid_reached", elem_valid, 1);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort.valid_low", elem_valid, 0);
        check("abort.busy_low", busy, 0);
        check("abort.clear_low", sep_buf_clear, 0);
        @(posedge clk); #1 sep_done = 1'b0;
        repeat (3) @(negedge clk);
        mon_en = 0;
        check("abort.done_cnt", done_cnt, 0);
        check("abort.err_cnt", err_cnt, 0);
        run_case("after_abort", 8, 0, 1, 0);

        // reset asserted mid-operation (in WAIT)
        begin_run();
        start_and_clear("midreset");
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check("midreset.busy", busy, 0);
        check("midreset.rows", mat_rows, 0);
        check("midreset.code", err_code, 0);
        check("midreset.done", load_done | load_err, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 0;
        check("midreset.pulses", done_cnt + err_cnt, 0);

        // randomized payloads
        for (int it = 0; it < 8; it++) begin
            int r, c, cnt;
            r = $urandom_range(0, 6);
            c = $urandom_range(0, 6);
            if ($urandom % 6 == 0) r = -r - 1;
            mem[0] = r;
            mem[1] = c;
            for (int i = 0; i < 40; i++) mem[2 + i] = $urandom;
            cnt = (r > 0 && c > 0) ? 2 + r * c : $urandom_range(0, 30);
            if ($urandom % 4 == 0) cnt = cnt + 1;
            run_case("random", cnt, ($urandom % 8 == 0), $urandom_range(1, 10), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
